// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared constants and FSM state type for the accumulator memory reader
package acc_pkg;

    localparam int IN_DATA_WIDTH_DEF = 8;
    localparam int AWIDTH_DEF        = 8;
    localparam int DRAIN_CYCLES      = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/acc_mem_reader.sv
// rtl/acc_mem_reader.sv - clears the accumulator, streams a run of memory words into it, pulses done
module acc_mem_reader
    import acc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = IN_DATA_WIDTH_DEF,
    parameter int AWIDTH        = AWIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic [AWIDTH-1:0]        base_addr_i,
    input  logic [AWIDTH:0]          num_cnt_i,
    output logic                     mem_ce_o,
    output logic [AWIDTH-1:0]        mem_addr_o,
    input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
    output logic                     acc_run_o,
    output logic                     acc_valid_o,
    output logic [IN_DATA_WIDTH-1:0] acc_number_o,
    output logic                     idle_o,
    output logic                     done_o
);

    localparam logic [AWIDTH:0] MAX_CNT    = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [1:0]      DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [AWIDTH-1:0]   r_addr;
    logic [AWIDTH:0]     r_remain;
    logic [1:0]          r_drain_cnt;
    logic                r_valid;
    logic [AWIDTH:0]     w_count;
    logic                w_last_issue;
    logic                w_drain_end;

    assign w_count      = (num_cnt_i > MAX_CNT) ? MAX_CNT : num_cnt_i;
    assign w_last_issue = (r_remain == (AWIDTH+1)'(1));
    assign w_drain_end  = (r_drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_next_state = ST_CLEAR;
            ST_CLEAR: w_next_state = (r_remain != '0) ? ST_READ : ST_DRAIN;
            ST_READ:  if (w_last_issue) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_drain_end) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_ce_o   = 1'b0;
        mem_addr_o = '0;
        acc_run_o  = 1'b0;
        done_o     = 1'b0;
        idle_o     = 1'b0;
        case (r_state)
            ST_IDLE:  idle_o = 1'b1;
            ST_CLEAR: acc_run_o = 1'b1;
            ST_READ: begin
                mem_ce_o   = 1'b1;
                mem_addr_o = r_addr;
            end
            ST_DONE:  done_o = 1'b1;
            default:  ;
        endcase
    end

    // Address wraps naturally at 2^AWIDTH; the remaining-word counter ends the burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remain    <= '0;
            r_drain_cnt <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid     <= mem_ce_o;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_addr   <= base_addr_i;
                        r_remain <= w_count;
                    end
                end
                ST_READ: begin
                    r_addr   <= r_addr + AWIDTH'(1);
                    r_remain <= r_remain - (AWIDTH+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // The accumulator keeps adding after valid falls, so the operand must be forced to zero.
    assign acc_valid_o  = r_valid;
    assign acc_number_o = r_valid ? mem_q_i : '0;

endmodule

// File: tb/tb_acc_mem_reader.sv
// tb/tb_acc_mem_reader.sv - self-checking bench for acc_mem_reader with memory and accumulator models
module tb_acc_mem_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  base_addr_i = '0;
    logic [8:0]  num_cnt_i = '0;
    logic        mem_ce_o;
    logic [7:0]  mem_addr_o;
    logic [7:0]  mem_q_i = '0;
    logic        acc_run_o;
    logic        acc_valid_o;
    logic [7:0]  acc_number_o;
    logic        idle_o;
    logic        done_o;

    logic [7:0]  mem [256];
    logic [15:0] acc = '0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int base;
        int n;
        int fill;
        int exp_done;
    } vec_t;
    vec_t vecs [6];

    acc_mem_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_cnt_i    (num_cnt_i),
        .mem_ce_o     (mem_ce_o),
        .mem_addr_o   (mem_addr_o),
        .mem_q_i      (mem_q_i),
        .acc_run_o    (acc_run_o),
        .acc_valid_o  (acc_valid_o),
        .acc_number_o (acc_number_o),
        .idle_o       (idle_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce_o) mem_q_i <= mem[mem_addr_o];
    end

    // Accumulator adds its operand every cycle it is not being cleared.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       acc <= '0;
        else if (acc_run_o) acc <= '0;
        else                acc <= acc + 16'(acc_number_o);
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int a = 0; a < 256; a++) begin
            case (kind)
                0:       mem[a] = 8'(a + 1);
                1:       mem[a] = 8'hFF;
                default: mem[a] = 8'($urandom);
            endcase
        end
    endtask

    function automatic logic [15:0] model_sum(input int base, input int n);
        int len = (n > 256) ? 256 : n;
        logic [15:0] s = '0;
        for (int i = 0; i < len; i++) s = s + 16'(mem[(base + i) % 256]);
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_ce"}, mem_ce_o, 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_acc_run"}, acc_run_o, 0);
        check({tag, "_acc_valid"}, acc_valid_o, 0);
        check({tag, "_acc_number"}, acc_number_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_idle"}, idle_o, 1);
    endtask

    // Called just after the edge ending cycle 0; returns at the negedge of the idle cycle.
    task automatic monitor(input int base, input int n, input int exp_done);
        int len = (n > 256) ? 256 : n;
        logic [15:0] exp_sum = model_sum(base, n);
        int run_cnt = 0, run_first = -1, ce_cnt = 0, ce_first = -1, ce_last = -1;
        int v_cnt = 0, v_first = -1, v_last = -1, done_cnt = 0, done_cyc = -1, idle_cyc = -1;
        int overlap = 0, addr_err = 0, data_err = 0;
        logic [15:0] res = '0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (acc_run_o) begin
                run_cnt++;
                if (run_first < 0) run_first = cyc;
            end
            if (mem_ce_o) begin
                if (mem_addr_o !== 8'(base + ce_cnt)) addr_err++;
                ce_cnt++;
                if (ce_first < 0) ce_first = cyc;
                ce_last = cyc;
            end
            if (acc_valid_o) begin
                if (acc_number_o !== mem[8'(base + v_cnt)]) data_err++;
                if (acc_run_o) overlap++;
                v_cnt++;
                if (v_first < 0) v_first = cyc;
                v_last = cyc;
            end else if (acc_number_o !== 8'd0) begin
                data_err++;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                res = acc;
            end
            if (idle_o && done_cnt > 0) begin
                idle_cyc = cyc;
                break;
            end
        end
        check("run_cycle", run_first, 1);
        check("run_count", run_cnt, 1);
        check("ce_count", ce_cnt, len);
        check("ce_first", ce_first, (len > 0) ? 2 : -1);
        check("ce_last", ce_last, (len > 0) ? len + 1 : -1);
        check("addr_seq_errors", addr_err, 0);
        check("valid_count", v_cnt, len);
        check("valid_first", v_first, (len > 0) ? 3 : -1);
        check("valid_span", (len > 0) ? v_last - v_first + 1 : v_cnt, len);
        check("valid_data_errors", data_err, 0);
        check("valid_run_overlap", overlap, 0);
        check("done_cycle", done_cyc, exp_done);
        check("done_count", done_cnt, 1);
        check("idle_cycle", idle_cyc, exp_done + 1);
        check("result", res, exp_sum);
    endtask

    task automatic do_run(input int base, input int n, input int exp_done);
        @(posedge clk);
        #1;
        base_addr_i = 8'(base);
        num_cnt_i   = 9'(n);
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        base_addr_i = 8'($urandom);
        num_cnt_i   = 9'($urandom);
        monitor(base, n, exp_done);
    endtask

    initial begin
        vecs[0] = '{base: 0,   n: 4,   fill: 0, exp_done: 8};
        vecs[1] = '{base: 254, n: 4,   fill: 2, exp_done: 8};
        vecs[2] = '{base: 17,  n: 0,   fill: 2, exp_done: 4};
        vecs[3] = '{base: 0,   n: 256, fill: 1, exp_done: 260};
        vecs[4] = '{base: 100, n: 300, fill: 2, exp_done: 260};
        vecs[5] = '{base: 255, n: 1,   fill: 2, exp_done: 5};

        fill(0);
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].fill);
            do_run(vecs[v].base, vecs[v].n, vecs[v].exp_done);
        end

        // Back-to-back with start held high; operands changed during the first run must be ignored.
        fill(2);
        @(posedge clk);
        #1;
        base_addr_i = 8'd30;
        num_cnt_i   = 9'd3;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        base_addr_i = 8'd200;
        num_cnt_i   = 9'd5;
        monitor(30, 3, 7);
        @(posedge clk);
        #1;
        base_addr_i = 8'($urandom);
        num_cnt_i   = 9'($urandom);
        monitor(200, 5, 9);
        start_i = 1'b0;

        // Asynchronous reset in the middle of a burst.
        fill(2);
        @(posedge clk);
        #1;
        base_addr_i = 8'd50;
        num_cnt_i   = 9'd10;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midread_ce", mem_ce_o, 1);
        check("midread_addr", mem_addr_o, 53);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        begin
            int done_seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (done_o) done_seen++;
            end
            check("no_done_in_reset", done_seen, 0);
        end
        reset_n = 1'b1;
        do_run(7, 5, 9);

        for (int k = 0; k < 8; k++) begin
            int b = $urandom_range(0, 255);
            int n = (k % 4 == 3) ? $urandom_range(0, 511) : $urandom_range(0, 20);
            fill(2);
            do_run(b, n, ((n > 256) ? 256 : n) + 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
